// File: rtl/clk_time_ctrl.sv
// Time-of-day controller: debounced MODE/UP keys, HH:MM:SS counter and a set-mode FSM.
// Define CLK_ALARM_EN to add the SET_ALARM state and the al_hour/al_min/alarm_out outputs.
module clk_time_ctrl #(
  parameter int HOUR_MAX = 23,
  parameter int MIN_MAX  = 59,
  parameter int SEC_MAX  = 59
`ifdef CLK_ALARM_EN
  ,
  parameter int ALARM_TICKS = 30
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_sec,
  input  logic       deb_clk,
  input  logic       key_mode,
  input  logic       key_up,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [1:0] mode,
  output logic       blink
`ifdef CLK_ALARM_EN
  ,
  output logic [4:0] al_hour,
  output logic [5:0] al_min,
  output logic       alarm_out
`endif
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HOUR  = 2'd1,
    S_MIN   = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  localparam logic [4:0] H_LAST = 5'(HOUR_MAX);
  localparam logic [5:0] M_LAST = 6'(MIN_MAX);
  localparam logic [5:0] S_LAST = 6'(SEC_MAX);

  logic deb_q_reg;
  logic deb_tick;

  always_ff @(posedge clk) begin
    if (rst) deb_q_reg <= 1'b0;
    else     deb_q_reg <= deb_clk;
  end

  assign deb_tick = deb_clk & ~deb_q_reg;

  logic [1:0] keys;
  logic [1:0] press;
  logic       mode_press;
  logic       up_press;

  assign keys = {key_up, key_mode};

  // Per key: 2-FF sync, sample on deb_tick, accept a level after two agreeing samples.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      logic sync1_reg, sync2_reg, samp_reg, stable_reg, press_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg  <= 1'b0;
          sync2_reg  <= 1'b0;
          samp_reg   <= 1'b0;
          stable_reg <= 1'b0;
          press_reg  <= 1'b0;
        end else begin
          sync1_reg <= keys[gi];
          sync2_reg <= sync1_reg;
          press_reg <= 1'b0;
          if (deb_tick) begin
            samp_reg <= sync2_reg;
            if (sync2_reg == samp_reg) begin
              stable_reg <= sync2_reg;
              press_reg  <= sync2_reg & ~stable_reg;
            end
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  assign mode_press = press[0];
  assign up_press   = press[1];

  state_t     state_reg;
  logic [4:0] hour_reg;
  logic [5:0] min_reg;
  logic [5:0] sec_reg;
  logic       blink_reg;

  logic       sec_last, min_last, hour_last;
  logic [4:0] hour_inc;
  logic [5:0] min_inc, sec_inc;
  logic [4:0] run_hour_next;
  logic [5:0] run_min_next, run_sec_next;

  always_comb begin
    sec_last      = (sec_reg == S_LAST);
    min_last      = (min_reg == M_LAST);
    hour_last     = (hour_reg == H_LAST);
    hour_inc      = hour_last ? 5'd0 : hour_reg + 5'd1;
    min_inc       = min_last ? 6'd0 : min_reg + 6'd1;
    sec_inc       = sec_last ? 6'd0 : sec_reg + 6'd1;
    run_sec_next  = sec_inc;
    run_min_next  = sec_last ? min_inc : min_reg;
    run_hour_next = (sec_last && min_last) ? hour_inc : hour_reg;
  end

`ifdef CLK_ALARM_EN
  localparam int ACW = (ALARM_TICKS > 2) ? $clog2(ALARM_TICKS) : 1;

  logic [4:0]     al_hour_reg;
  logic [5:0]     al_min_reg;
  logic           alarm_reg;
  logic [ACW-1:0] al_cnt_reg;
  logic           al_match;

  assign al_match = (run_hour_next == al_hour_reg) && (run_min_next == al_min_reg) &&
                    (run_sec_next == 6'd0);
`endif

  // Mode key always wins over UP and over the seconds tick in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_RUN;
      hour_reg  <= '0;
      min_reg   <= '0;
      sec_reg   <= '0;
      blink_reg <= 1'b0;
`ifdef CLK_ALARM_EN
      al_hour_reg <= '0;
      al_min_reg  <= '0;
`endif
    end else begin
      case (state_reg)
        S_RUN: begin
          blink_reg <= 1'b0;
          if (mode_press) begin
            state_reg <= S_HOUR;
            blink_reg <= 1'b1;
          end else if (en_sec) begin
            sec_reg  <= run_sec_next;
            min_reg  <= run_min_next;
            hour_reg <= run_hour_next;
          end
        end
        S_HOUR: begin
          if (mode_press) begin
            state_reg <= S_MIN;
            blink_reg <= 1'b1;
          end else begin
            if (up_press) hour_reg <= hour_inc;
            if (deb_tick) blink_reg <= ~blink_reg;
          end
        end
        S_MIN: begin
          if (mode_press) begin
            sec_reg <= '0;
`ifdef CLK_ALARM_EN
            state_reg <= S_ALARM;
            blink_reg <= 1'b1;
`else
            state_reg <= S_RUN;
            blink_reg <= 1'b0;
`endif
          end else begin
            if (up_press) min_reg <= min_inc;
            if (deb_tick) blink_reg <= ~blink_reg;
          end
        end
`ifdef CLK_ALARM_EN
        S_ALARM: begin
          if (mode_press) begin
            state_reg <= S_RUN;
            blink_reg <= 1'b0;
          end else begin
            if (up_press) begin
              al_min_reg <= (al_min_reg == M_LAST) ? 6'd0 : al_min_reg + 6'd1;
              if (al_min_reg == M_LAST)
                al_hour_reg <= (al_hour_reg == H_LAST) ? 5'd0 : al_hour_reg + 5'd1;
            end
            if (deb_tick) blink_reg <= ~blink_reg;
          end
        end
`endif
        default: begin
          state_reg <= S_RUN;
          blink_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLK_ALARM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_reg  <= 1'b0;
      al_cnt_reg <= '0;
    end else if (state_reg != S_RUN || mode_press || up_press) begin
      alarm_reg  <= 1'b0;
      al_cnt_reg <= '0;
    end else if (en_sec) begin
      if (al_match) begin
        alarm_reg  <= 1'b1;
        al_cnt_reg <= '0;
      end else if (alarm_reg) begin
        if (al_cnt_reg == ACW'(ALARM_TICKS - 1)) alarm_reg <= 1'b0;
        else                                     al_cnt_reg <= al_cnt_reg + 1'b1;
      end
    end
  end

  assign al_hour   = al_hour_reg;
  assign al_min    = al_min_reg;
  assign alarm_out = alarm_reg;
`endif

  assign hour  = hour_reg;
  assign min   = min_reg;
  assign sec   = sec_reg;
  assign mode  = state_reg;
  assign blink = blink_reg;

endmodule
